huffman_decoder: RTL and testbench

//  Receive end of the Huffman link: inverts Huffman_encoder. Loads the code table the encoder

---
 rtl/huffman_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_huffman_decoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_decoder.sv
// Huffman decoder: loads a symbol/length/code table, then decodes an MSB-first serial bitstream.
// Optional HUFF_DEC_COUNT_EN adds a 16-bit sym_count output counting decoded symbols.
module huffman_decoder #(
  parameter int unsigned SYMBOL_WIDTH = 8,
  parameter int unsigned LEN_WIDTH    = 4,
  parameter int unsigned CODE_WIDTH   = 8,
  parameter int unsigned TABLE_DEPTH  = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    table_we,
  input  logic [SYMBOL_WIDTH-1:0] table_symbol,
  input  logic [LEN_WIDTH-1:0]    table_length,
  input  logic [CODE_WIDTH-1:0]   table_code,
  input  logic                    table_done,
  input  logic                    flush,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic                    bit_ready,
  output logic [SYMBOL_WIDTH-1:0] sym_out,
  output logic [LEN_WIDTH-1:0]    sym_length,
  output logic                    sym_valid,
  output logic                    error,
  output logic                    table_full,
`ifdef HUFF_DEC_COUNT_EN
  output logic [15:0]             sym_count,
`endif
  output logic [1:0]              dec_state
);

  localparam int unsigned CNT_W = $clog2(TABLE_DEPTH + 1);
  localparam int unsigned N_W   = $clog2(CODE_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'b00,
    ST_DECODE = 2'b01,
    ST_ERROR  = 2'b10
  } state_e;

  typedef struct packed {
    logic                    valid;
    logic [SYMBOL_WIDTH-1:0] sym;
    logic [LEN_WIDTH-1:0]    len;
    logic [CODE_WIDTH-1:0]   code;
  } entry_t;

  state_e                  state_q, state_d;
  entry_t                  tbl_q [TABLE_DEPTH];
  entry_t                  tbl_d [TABLE_DEPTH];
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CODE_WIDTH-1:0]   acc_q, acc_d;
  logic [N_W-1:0]          n_q, n_d;
  logic [SYMBOL_WIDTH-1:0] sym_out_q, sym_out_d;
  logic [LEN_WIDTH-1:0]    sym_length_q, sym_length_d;
  logic                    sym_valid_q, sym_valid_d;
  logic                    error_q, error_d;
  logic                    bit_ready_q, bit_ready_d;
  logic                    table_full_q, table_full_d;
`ifdef HUFF_DEC_COUNT_EN
  logic [15:0]             sym_count_q, sym_count_d;
`endif

  logic [CODE_WIDTH-1:0]   acc_next;
  logic [N_W-1:0]          n_next;
  logic [CODE_WIDTH-1:0]   mask;
  logic                    match_hit;
  entry_t                  match_e;
  logic                    entry_ok;

  // Parallel match of the shifted accumulator against every entry; lowest index wins.
  always_comb begin
    acc_next  = (acc_q << 1) | CODE_WIDTH'(bit_in);
    n_next    = n_q + N_W'(1);
    mask      = '0;
    match_hit = 1'b0;
    match_e   = '0;
    for (int i = 0; i < int'(CODE_WIDTH); i++) begin
      mask[i] = (int'(n_next) > i);
    end
    for (int i = int'(TABLE_DEPTH) - 1; i >= 0; i--) begin
      if (tbl_q[i].valid && (32'(tbl_q[i].len) == 32'(n_next)) &&
          (((tbl_q[i].code ^ acc_next) & mask) == '0)) begin
        match_hit = 1'b1;
        match_e   = tbl_q[i];
      end
    end
  end

  assign entry_ok = (count_q < CNT_W'(TABLE_DEPTH)) && (table_length != '0) &&
                    (32'(table_length) <= 32'(CODE_WIDTH));

  always_comb begin
    state_d      = state_q;
    tbl_d        = tbl_q;
    count_d      = count_q;
    acc_d        = acc_q;
    n_d          = n_q;
    sym_out_d    = sym_out_q;
    sym_length_d = sym_length_q;
    sym_valid_d  = 1'b0;
    error_d      = error_q;

    case (state_q)
      ST_LOAD: begin
        if (table_we && entry_ok) begin
          for (int i = 0; i < int'(TABLE_DEPTH); i++) begin
            if (CNT_W'(i) == count_q) begin
              tbl_d[i] = '{valid: 1'b1, sym: table_symbol, len: table_length, code: table_code};
            end
          end
          count_d = count_q + CNT_W'(1);
        end
        if (table_done) begin
          if (count_d != '0) begin
            state_d = ST_DECODE;
          end else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
      end
      ST_DECODE: begin
        if (flush) begin
          acc_d = '0;
          n_d   = '0;
        end else if (bit_valid) begin
          if (match_hit) begin
            sym_valid_d  = 1'b1;
            sym_out_d    = match_e.sym;
            sym_length_d = match_e.len;
            acc_d        = '0;
            n_d          = '0;
          end else if (n_next == N_W'(CODE_WIDTH)) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
            acc_d   = '0;
            n_d     = '0;
          end else begin
            acc_d = acc_next;
            n_d   = n_next;
          end
        end
      end
      ST_ERROR: begin
        if (flush) begin
          acc_d   = '0;
          n_d     = '0;
          error_d = 1'b0;
          state_d = (count_q != '0) ? ST_DECODE : ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase

    bit_ready_d  = (state_d == ST_DECODE);
    table_full_d = (count_d == CNT_W'(TABLE_DEPTH));
`ifdef HUFF_DEC_COUNT_EN
    sym_count_d  = sym_count_q + 16'(sym_valid_d);
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_LOAD;
      for (int i = 0; i < int'(TABLE_DEPTH); i++) begin
        tbl_q[i] <= '0;
      end
      count_q      <= '0;
      acc_q        <= '0;
      n_q          <= '0;
      sym_out_q    <= '0;
      sym_length_q <= '0;
      sym_valid_q  <= 1'b0;
      error_q      <= 1'b0;
      bit_ready_q  <= 1'b0;
      table_full_q <= 1'b0;
`ifdef HUFF_DEC_COUNT_EN
      sym_count_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      tbl_q        <= tbl_d;
      count_q      <= count_d;
      acc_q        <= acc_d;
      n_q          <= n_d;
      sym_out_q    <= sym_out_d;
      sym_length_q <= sym_length_d;
      sym_valid_q  <= sym_valid_d;
      error_q      <= error_d;
      bit_ready_q  <= bit_ready_d;
      table_full_q <= table_full_d;
`ifdef HUFF_DEC_COUNT_EN
      sym_count_q  <= sym_count_d;
`endif
    end
  end

  assign dec_state  = state_q;
  assign bit_ready  = bit_ready_q;
  assign sym_out    = sym_out_q;
  assign sym_length = sym_length_q;
  assign sym_valid  = sym_valid_q;
  assign error      = error_q;
  assign table_full = table_full_q;
`ifdef HUFF_DEC_COUNT_EN
  assign sym_count  = sym_count_q;
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder: directed vector table, hand sequences, and
// randomized tables/streams checked against a prefix-lookup reference model.
module tb_huffman_decoder;

  logic       clock, reset_n;
  logic       table_we, table_done, flush, bit_in, bit_valid;
  logic [7:0] table_symbol;
  logic [3:0] table_length;
  logic [7:0] table_code;
  logic       bit_ready, sym_valid, error, table_full;
  logic [7:0] sym_out;
  logic [3:0] sym_length;
  logic [1:0] dec_state;
`ifdef HUFF_DEC_COUNT_EN
  logic [15:0] sym_count;
`endif

  huffman_decoder dut (
    .clock(clock), .reset_n(reset_n),
    .table_we(table_we), .table_symbol(table_symbol), .table_length(table_length),
    .table_code(table_code), .table_done(table_done), .flush(flush),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .sym_out(sym_out), .sym_length(sym_length), .sym_valid(sym_valid),
    .error(error), .table_full(table_full),
`ifdef HUFF_DEC_COUNT_EN
    .sym_count(sym_count),
`endif
    .dec_state(dec_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: table as plain arrays, pending code as value + bit count.
  int m_sym [8];
  int m_len [8];
  int m_code[8];
  int m_cnt, m_state, m_val, m_nbits, m_err, m_sv, m_osym, m_olen, m_strobes;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_cnt = 0; m_state = 0; m_val = 0; m_nbits = 0; m_err = 0;
    m_sv = 0; m_osym = 0; m_olen = 0; m_strobes = 0;
  endtask

  task automatic m_step(input int we, input int sym, input int len, input int code,
                        input int done, input int valid, input int b, input int fl);
    m_sv = 0;
    if (m_state == 0) begin
      if (we != 0 && m_cnt < 8 && len >= 1 && len <= 8) begin
        m_sym[m_cnt] = sym; m_len[m_cnt] = len; m_code[m_cnt] = code; m_cnt++;
      end
      if (done != 0) begin
        m_state = (m_cnt > 0) ? 1 : 2;
        m_err   = (m_cnt > 0) ? 0 : 1;
      end
    end else if (fl != 0) begin
      m_val = 0; m_nbits = 0; m_err = 0;
      m_state = (m_cnt > 0) ? 1 : 0;
    end else if (m_state == 1 && valid != 0) begin
      int found;
      m_val = m_val * 2 + b;
      m_nbits++;
      found = -1;
      for (int i = 0; i < m_cnt; i++) begin
        if (found < 0 && m_len[i] == m_nbits &&
            (m_code[i] % (1 << m_nbits)) == (m_val % (1 << m_nbits)))
          found = i;
      end
      if (found >= 0) begin
        m_sv = 1; m_osym = m_sym[found]; m_olen = m_len[found];
        m_strobes++; m_val = 0; m_nbits = 0;
      end else if (m_nbits == 8) begin
        m_state = 2; m_err = 1; m_val = 0; m_nbits = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".sym_valid"}, int'(sym_valid), m_sv);
    check({tag, ".sym_out"}, int'(sym_out), m_osym);
    check({tag, ".sym_length"}, int'(sym_length), m_olen);
    check({tag, ".error"}, int'(error), m_err);
    check({tag, ".dec_state"}, int'(dec_state), m_state);
    check({tag, ".bit_ready"}, int'(bit_ready), (m_state == 1) ? 1 : 0);
    check({tag, ".table_full"}, int'(table_full), (m_cnt == 8) ? 1 : 0);
`ifdef HUFF_DEC_COUNT_EN
    check({tag, ".sym_count"}, int'(sym_count), m_strobes % 65536);
`endif
  endtask

  // One clock: drive inputs, advance model, then compare outputs after the edge.
  task automatic drive(input string tag, input int we, input int sym, input int len,
                       input int code, input int done, input int valid, input int b,
                       input int fl);
    table_we = 1'(we); table_symbol = 8'(sym); table_length = 4'(len);
    table_code = 8'(code); table_done = 1'(done); bit_valid = 1'(valid);
    bit_in = 1'(b); flush = 1'(fl);
    m_step(we, sym, len, code, done, valid, b, fl);
    tick();
    table_we = 0; table_done = 0; bit_valid = 0; bit_in = 0; flush = 0;
    compare_all(tag);
  endtask

  task automatic do_reset();
    reset_n = 0;
    table_we = 0; table_done = 0; bit_valid = 0; bit_in = 0; flush = 0;
    table_symbol = 0; table_length = 0; table_code = 0;
    m_reset();
    #2;
    reset_n = 1;
    tick();
  endtask

  task automatic load_abcd();
    drive("ldA", 1, 8'h41, 1, 8'b0, 0, 0, 0, 0);
    drive("ldB", 1, 8'h42, 2, 8'b10, 0, 0, 0, 0);
    drive("ldC", 1, 8'h43, 3, 8'b110, 0, 0, 0, 0);
    drive("ldD", 1, 8'h44, 3, 8'b111, 1, 0, 0, 0);
  endtask

  typedef struct {
    logic       b;
    logic       sv;
    logic [7:0] sym;
    logic [3:0] len;
  } vec_t;

  vec_t vt [9];

  function automatic vec_t mk(input logic b, input logic sv, input logic [7:0] s,
                              input logic [3:0] l);
    vec_t v;
    v.b = b; v.sv = sv; v.sym = s; v.len = l;
    return v;
  endfunction

  initial begin
    vt[0] = mk(0, 1, 8'h41, 1); vt[1] = mk(1, 0, 0, 0); vt[2] = mk(0, 1, 8'h42, 2);
    vt[3] = mk(1, 0, 0, 0);     vt[4] = mk(1, 0, 0, 0); vt[5] = mk(0, 1, 8'h43, 3);
    vt[6] = mk(1, 0, 0, 0);     vt[7] = mk(1, 0, 0, 0); vt[8] = mk(1, 1, 8'h44, 3);

    // Reset mid-load: outputs clear asynchronously and the table is lost.
    do_reset();
    compare_all("rst_init");
    drive("w1", 1, 8'h11, 2, 1, 0, 0, 0, 0);
    drive("w2", 1, 8'h12, 2, 2, 0, 0, 0, 0);
    reset_n = 0;
    m_reset();
    #2;
    compare_all("rst_async");
    reset_n = 1;
    tick();
    drive("empty_done", 0, 0, 0, 0, 1, 0, 0, 0);
    check("empty_err", int'(error), 1);
    check("empty_state", int'(dec_state), 2);
    drive("empty_flush", 0, 0, 0, 0, 0, 0, 0, 1);

    // Directed ABCD stream via vector table.
    do_reset();
    load_abcd();
    for (int i = 0; i < 9; i++) begin
      drive($sformatf("abcd%0d", i), 0, 0, 0, 0, 0, 1, int'(vt[i].b), 0);
      check($sformatf("vt%0d.sv", i), int'(sym_valid), int'(vt[i].sv));
      if (vt[i].sv) begin
        check($sformatf("vt%0d.sym", i), int'(sym_out), int'(vt[i].sym));
        check($sformatf("vt%0d.len", i), int'(sym_length), int'(vt[i].len));
      end
    end

    // Three back-to-back 1-bit codes.
    for (int i = 0; i < 3; i++) begin
      drive($sformatf("b2b%0d", i), 0, 0, 0, 0, 0, 1, 0, 0);
      check($sformatf("b2b%0d.sv", i), int'(sym_valid), 1);
      check($sformatf("b2b%0d.sym", i), int'(sym_out), 8'h41);
    end

    // Gap of five idle clocks inside a codeword.
    drive("gap_b1", 0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) drive("gap_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    drive("gap_b0", 0, 0, 0, 0, 0, 1, 0, 0);
    check("gap.sym", int'(sym_out), 8'h42);
    check("gap.sv", int'(sym_valid), 1);

    // No match within CODE_WIDTH bits, then flush recovers.
    do_reset();
    drive("ld101", 1, 8'h55, 3, 8'b101, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive($sformatf("ones%0d", i), 0, 0, 0, 0, 0, 1, 1, 0);
      check($sformatf("ones%0d.err", i), int'(error), (i == 7) ? 1 : 0);
    end
    check("ones.state", int'(dec_state), 2);
    check("ones.ready", int'(bit_ready), 0);
    drive("err_flush", 0, 0, 0, 0, 0, 0, 0, 1);
    check("flush.err", int'(error), 0);
    check("flush.state", int'(dec_state), 1);

    // Invalid lengths ignored, ninth write ignored once full.
    do_reset();
    drive("len0", 1, 8'hE0, 0, 0, 0, 0, 0, 0);
    drive("len9", 1, 8'hE9, 9, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++)
      drive($sformatf("fill%0d", i), 1, 8'h60 + i, 3, i % 8, 0, 0, 0, 0);
    check("full", int'(table_full), 1);
    drive("full_done", 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      drive("full_bits", 0, 0, 0, 0, 0, 1, int'($urandom_range(0, 1)), 0);

    // Randomized tables (duplicates allowed) and streams with gaps and flushes.
    for (int r = 0; r < 20; r++) begin
      int n;
      do_reset();
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) begin
        int l;
        l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 3));
        drive("rld", 1, int'($urandom_range(0, 255)), l, int'($urandom_range(0, 255)),
              (i == n - 1) ? 1 : 0, 0, 0, 0);
      end
      if (m_state == 0) drive("rdone", 0, 0, 0, 0, 1, 0, 0, 0);
      for (int c = 0; c < 150; c++) begin
        int fl;
        fl = (m_state == 2) ? int'($urandom_range(0, 2) == 0) : int'($urandom_range(0, 40) == 0);
        drive("rnd", 0, 0, 0, 0, 0, int'($urandom_range(0, 9) < 7),
              int'($urandom_range(0, 1)), fl);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
